// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file: default widths and the
// active levels of the reset and enable strobes.
package wb_regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_CNT_W    = 32;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair: both halves are always written together under one enable
// and cleared by the active-low synchronous reset.
module hilo_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we == WRITE_ENABLE) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule : hilo_reg

// File: rtl/wb_regfile.sv
// Write-back stage register file: 32 GPRs with r0 tied to zero, HI/LO pair,
// two combinational read ports with write-to-read bypass, retired-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [CNT_W-1:0]  wb_cnt
);

    logic              gpr_we;
    logic [DATA_W-1:0] gpr_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign gpr_we = (wb_wreg == WRITE_ENABLE) && (wb_wd != '0);

    // Entry 0 never matches gpr_we, so it simply holds its reset value of zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_gpr
            logic [DATA_W-1:0] gpr_d;

            always_comb begin
                gpr_d = gpr_q[gi];
                if (gpr_we && (wb_wd == ADDR_W'(gi))) begin
                    gpr_d = wb_wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (rst == RST_ENABLE) begin
                    gpr_q[gi] <= '0;
                end else begin
                    gpr_q[gi] <= gpr_d;
                end
            end
        end
    endgenerate

    function automatic logic [DATA_W-1:0] read_mux(
        input logic              rst_i,
        input logic              re_i,
        input logic [ADDR_W-1:0] raddr_i,
        input logic              wreg_i,
        input logic [ADDR_W-1:0] wd_i,
        input logic [DATA_W-1:0] wdata_i,
        input logic [DATA_W-1:0] stored_i
    );
        if (rst_i == RST_ENABLE)                             return '0;
        else if (re_i != READ_ENABLE)                        return '0;
        else if (raddr_i == '0)                              return '0;
        else if ((wreg_i == WRITE_ENABLE) && (raddr_i == wd_i)) return wdata_i;
        else                                                 return stored_i;
    endfunction

    assign rdata1 = read_mux(rst, re1, raddr1, wb_wreg, wb_wd, wb_wdata, gpr_q[raddr1]);
    assign rdata2 = read_mux(rst, re2, raddr2, wb_wreg, wb_wd, wb_wdata, gpr_q[raddr2]);

    hilo_reg #(
        .DATA_W(DATA_W)
    ) u_hilo (
        .clk (clk),
        .rst (rst),
        .we  (wb_whilo),
        .hi_i(wb_hi),
        .lo_i(wb_lo),
        .hi_o(hi_o),
        .lo_o(lo_o)
    );

    // One count per committing cycle, even when GPR and HI/LO both commit.
    always_comb begin
        cnt_d = cnt_q;
        if (gpr_we || (wb_whilo == WRITE_ENABLE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wb_cnt = cnt_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Randomized and directed checking of wb_regfile against an array-based model of
// the register file, HI/LO pair and commit counter.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata, wb_hi, wb_lo;
    logic        wb_whilo;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2, hi_o, lo_o, wb_cnt;
    logic [31:0] n_rdata1, n_rdata2, n_hi, n_lo;
    logic [3:0]  n_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .wb_cnt(wb_cnt)
    );

    // Narrow-counter copy lets the counter wrap quickly.
    wb_regfile #(.CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .re1(re1), .raddr1(raddr1), .rdata1(n_rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(n_rdata2),
        .hi_o(n_hi), .lo_o(n_lo), .wb_cnt(n_cnt)
    );

    // Behavioural model
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo, m_cnt;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
            m_hi   = 32'h0;
            m_lo   = 32'h0;
            m_cnt  = 32'h0;
            chk_en = 1'b1;
        end else begin
            if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
            if (wb_whilo) begin
                m_hi = wb_hi;
                m_lo = wb_lo;
            end
            if ((wb_wreg && wb_wd != 5'd0) || wb_whilo) m_cnt = m_cnt + 32'd1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (!rst || !re || a == 5'd0) return 32'h0;
        if (wb_wreg && a == wb_wd) return wb_wdata;
        return m_gpr[a];
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check32("rdata1", rdata1, exp_rd(re1, raddr1));
            check32("rdata2", rdata2, exp_rd(re2, raddr2));
            check32("hi_o", hi_o, m_hi);
            check32("lo_o", lo_o, m_lo);
            check32("wb_cnt", wb_cnt, m_cnt);
            check32("n_rdata1", n_rdata1, exp_rd(re1, raddr1));
            check32("n_cnt", {28'h0, n_cnt}, {28'h0, m_cnt[3:0]});
        end
    end

    task automatic begin_cycle();
        @(negedge clk);
        rst = 1'b1; wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'h0;
        wb_whilo = 1'b0; wb_hi = 32'h0; wb_lo = 32'h0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rst = 1'b0; wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEAD_BEEF;
        wb_whilo = 1'b0; wb_hi = 32'h0; wb_lo = 32'h0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;

        // Reset overrides a concurrent write
        for (int i = 0; i < 2; i++) begin
            begin_cycle();
            rst = 1'b0; wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEAD_BEEF;
        end
        begin_cycle();
        re1 = 1'b1; raddr1 = 5'd5;
        settle();
        check32("t1_rdata1", rdata1, 32'h0);
        check32("t1_hi", hi_o, 32'h0);
        check32("t1_lo", lo_o, 32'h0);
        check32("t1_cnt", wb_cnt, 32'h0);

        // Bypass, then committed value
        begin_cycle();
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h1234_5678; re1 = 1'b1; raddr1 = 5'd3;
        settle();
        check32("t2_bypass", rdata1, 32'h1234_5678);
        begin_cycle();
        re1 = 1'b1; raddr1 = 5'd3;
        settle();
        check32("t2_stored", rdata1, 32'h1234_5678);
        check32("t2_cnt", wb_cnt, 32'd1);

        // r0 writes are dropped and not counted
        begin_cycle();
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFF_FFFF; re1 = 1'b1; raddr1 = 5'd0;
        settle();
        check32("t3_r0_now", rdata1, 32'h0);
        begin_cycle();
        re1 = 1'b1; raddr1 = 5'd0;
        settle();
        check32("t3_r0_after", rdata1, 32'h0);
        check32("t3_cnt", wb_cnt, 32'd1);

        // GPR and HI/LO in one cycle count once
        begin_cycle();
        wb_whilo = 1'b1; wb_hi = 32'hA; wb_lo = 32'hB;
        wb_wreg = 1'b1; wb_wd = 5'd31; wb_wdata = 32'hC;
        settle();
        check32("t4_hi_pre", hi_o, 32'h0);
        begin_cycle();
        re1 = 1'b1; raddr1 = 5'd31;
        settle();
        check32("t4_hi", hi_o, 32'hA);
        check32("t4_lo", lo_o, 32'hB);
        check32("t4_r31", rdata1, 32'hC);
        check32("t4_cnt", wb_cnt, 32'd2);

        // Read enables
        begin_cycle();
        re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b0; raddr2 = 5'd31;
        settle();
        check32("t5_re2_off", rdata2, 32'h0);
        check32("t5_rd1", rdata1, 32'hC);
        begin_cycle();
        re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b1; raddr2 = 5'd31;
        settle();
        check32("t5_both1", rdata1, 32'hC);
        check32("t5_both2", rdata2, 32'hC);
        check32("t5_ncnt", {28'h0, n_cnt}, 32'd2);

        // Counter wrap on the 4-bit copy; the wrapping write still lands
        for (int i = 0; i < 14; i++) begin
            begin_cycle();
            wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'(i);
        end
        begin_cycle();
        re1 = 1'b1; raddr1 = 5'd7;
        settle();
        check32("t6_ncnt_wrap", {28'h0, n_cnt}, 32'h0);
        check32("t6_cnt", wb_cnt, 32'd16);
        check32("t6_write", n_rdata1, 32'd13);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            begin_cycle();
            rst      = ($urandom_range(0, 63) != 0);
            wb_wreg  = ($urandom_range(0, 2) != 0);
            wb_wd    = 5'($urandom_range(0, 31));
            wb_wdata = $urandom;
            wb_whilo = ($urandom_range(0, 3) == 0);
            wb_hi    = $urandom;
            wb_lo    = $urandom;
            re1      = ($urandom_range(0, 4) != 0);
            re2      = ($urandom_range(0, 4) != 0);
            raddr1   = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom_range(0, 31));
            raddr2   = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom_range(0, 31));
        end

        begin_cycle();
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_regfile
